// File: rtl/riscv_pkg.sv
// Shared definitions for the result unloader: FSM state encoding and frame layout.
package riscv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR_RD,
        HDR_CAP,
        SEND,
        FETCH,
        FILL,
        SUM,
        FINISH
    } unload_state_t;

    // Words ahead of result[0] in a frame (the latched clock_count).
    localparam int FRAME_HDR_WORDS = 1;

endpackage

// File: rtl/result_unloader.sv
// Streams clock_count followed by result[0..rows-1] from data memory when the CPU signals done.
// Define UNLOAD_CHECKSUM_EN to append an XOR checksum word that carries out_last.
module result_unloader
    import riscv_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int RESULT_BASE = 512,
    parameter int MAX_ROWS    = 512
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              done,
    input  logic [31:0]       clock_count,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic              out_last,
    output logic              busy,
    output logic              err
);

    unload_state_t r_state;
    logic          r_done_q;
    logic          r_arm;
    logic [31:0]   r_cc;
    logic [31:0]   r_rows;
    logic [31:0]   r_wcnt;
`ifdef UNLOAD_CHECKSUM_EN
    logic [31:0]   r_sum;
`endif

    logic              w_done_rise;
    logic              w_rows_bad;
    logic [ADDR_W-1:0] w_fetch_addr;

    // r_arm stays low until done has been seen low, so a level held through reset is not an edge.
    assign w_done_rise  = done & ~r_done_q & r_arm;
    assign w_rows_bad   = ($signed(mem_rd_data) < 0) || ($signed(mem_rd_data) > MAX_ROWS);
    // r_wcnt is the frame word just sent; the next result index wraps with the address width.
    assign w_fetch_addr = ADDR_W'(32'(RESULT_BASE) + r_wcnt + 32'd1 - 32'(FRAME_HDR_WORDS));
    assign busy         = (r_state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_done_q  <= 1'b0;
            r_arm     <= 1'b0;
            r_cc      <= '0;
            r_rows    <= '0;
            r_wcnt    <= '0;
`ifdef UNLOAD_CHECKSUM_EN
            r_sum     <= '0;
`endif
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            err       <= 1'b0;
        end else begin
            r_done_q <= done;
            r_arm    <= r_arm | ~done;
            case (r_state)
                IDLE: begin
                    if (w_done_rise) begin
                        r_cc      <= clock_count;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= '0;
                        r_state   <= HDR_RD;
                    end
                end
                HDR_RD: begin
                    mem_rd_en <= 1'b0;
                    r_state   <= HDR_CAP;
                end
                HDR_CAP: begin
                    r_rows    <= mem_rd_data;
                    r_wcnt    <= '0;
`ifdef UNLOAD_CHECKSUM_EN
                    r_sum     <= '0;
`endif
                    out_valid <= 1'b1;
                    out_data  <= r_cc;
                    r_state   <= SEND;
                    if (w_rows_bad) begin
                        err      <= 1'b1;
                        out_last <= 1'b1;
                    end else begin
`ifdef UNLOAD_CHECKSUM_EN
                        out_last <= 1'b0;
`else
                        out_last <= (mem_rd_data == 32'd0);
`endif
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            out_last <= 1'b0;
                            r_state  <= FINISH;
`ifdef UNLOAD_CHECKSUM_EN
                        end else if (r_wcnt == r_rows) begin
                            out_valid <= 1'b1;
                            out_data  <= r_sum;
                            out_last  <= 1'b1;
                            r_state   <= SUM;
`endif
                        end else begin
                            r_wcnt    <= r_wcnt + 32'd1;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= w_fetch_addr;
                            r_state   <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    mem_rd_en <= 1'b0;
                    r_state   <= FILL;
                end
                FILL: begin
                    out_data  <= mem_rd_data;
                    out_valid <= 1'b1;
`ifdef UNLOAD_CHECKSUM_EN
                    out_last  <= 1'b0;
                    r_sum     <= r_sum ^ mem_rd_data;
`else
                    out_last  <= (r_wcnt == r_rows);
`endif
                    r_state   <= SEND;
                end
`ifdef UNLOAD_CHECKSUM_EN
                SUM: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        r_state   <= FINISH;
                    end
                end
`endif
                FINISH:  r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_result_unloader.sv
// Directed bench for result_unloader: reference frame, stalls, row-count edge cases, reset abort.
module tb_result_unloader;

    logic        clk = 1'b0;
    logic        reset;
    logic        done;
    logic [31:0] clock_count;
    logic        mem_rd_en;
    logic [9:0]  mem_addr;
    logic [31:0] mem_rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        err;

    logic [31:0] mem [0:1023];
    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    result_unloader #(.ADDR_W(10), .RESULT_BASE(512), .MAX_ROWS(512)) dut (
        .clk(clk), .reset(reset), .done(done), .clock_count(clock_count),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .err(err)
    );

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait for a word, check it and the idle gap before it, hold it for `stalls` cycles, then accept.
    task automatic get_word(input logic [31:0] ed, input logic el, input int egap,
                            input int stalls, input string tag);
        int n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk(32'(out_valid), 32'd1, {tag, "_valid"});
        if (egap >= 0) chk(32'(n), 32'(egap), {tag, "_gap"});
        chk(out_data, ed, {tag, "_data"});
        chk(32'(out_last), 32'(el), {tag, "_last"});
        if (stalls > 0) out_ready = 1'b0;
        for (int s = 0; s < stalls; s++) begin
            step();
            chk(32'(out_valid), 32'd1, {tag, "_stall_valid"});
            chk(out_data, ed, {tag, "_stall_data"});
            chk(32'(out_last), 32'(el), {tag, "_stall_last"});
        end
        out_ready = 1'b1;
        step();
    endtask

    // Produce a clean done rising edge with clock_count=cc, then scramble clock_count.
    task automatic start_frame(input logic [31:0] cc);
        done = 1'b0;
        step();
        done = 1'b1;
        clock_count = cc;
        step();
        clock_count = 32'hDEAD_BEEF;
        chk(32'(busy), 32'd1, "start_busy");
        chk(32'(mem_rd_en), 32'd1, "start_rden");
        chk(32'(mem_addr), 32'd0, "start_addr");
    endtask

    task automatic frame_ref(input logic [31:0] cc, input int stalls, input string tag);
        start_frame(cc);
        get_word(cc, 1'b0, -1, stalls, {tag, "_w0"});
        chk(32'(mem_rd_en), 32'd1, {tag, "_fetch_rden"});
        chk(32'(mem_addr), 32'd512, {tag, "_fetch_addr"});
        chk(32'(out_valid), 32'd0, {tag, "_fetch_valid"});
        get_word(32'd5, 1'b0, 2, stalls, {tag, "_w1"});
        get_word(32'hFFFF_FFFE, 1'b0, 2, stalls, {tag, "_w2"});
`ifdef UNLOAD_CHECKSUM_EN
        get_word(32'd7, 1'b0, 2, stalls, {tag, "_w3"});
        get_word(32'hFFFF_FFFC, 1'b1, 0, stalls, {tag, "_sum"});
`else
        get_word(32'd7, 1'b1, 2, stalls, {tag, "_w3"});
`endif
        chk(32'(busy), 32'd1, {tag, "_finish_busy"});
        chk(32'(out_valid), 32'd0, {tag, "_finish_valid"});
        step();
        chk(32'(busy), 32'd0, {tag, "_idle_busy"});
        chk(32'(err), 32'd0, {tag, "_err"});
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0BAD_0000 + 32'(i);
        mem[0] = 32'd3;
        mem[1] = 32'd4;
        mem[512] = 32'd5;
        mem[513] = 32'hFFFF_FFFE;
        mem[514] = 32'd7;
        reset = 1'b1;
        done = 1'b0;
        clock_count = 32'd0;
        out_ready = 1'b1;
        step();
        step();
        chk(32'(out_valid), 32'd0, "rst_valid");
        chk(32'(out_last), 32'd0, "rst_last");
        chk(out_data, 32'd0, "rst_data");
        chk(32'(mem_rd_en), 32'd0, "rst_rden");
        chk(32'(mem_addr), 32'd0, "rst_addr");
        chk(32'(busy), 32'd0, "rst_busy");
        chk(32'(err), 32'd0, "rst_err");
        reset = 1'b0;

        // Reference frame, sink always ready.
        frame_ref(32'd120, 0, "ref");
        // Same frame, sink alternating stall/accept on every word.
        frame_ref(32'd120, 1, "stall");

        // rows == 0: only the count word (plus a zero checksum when enabled).
        mem[0] = 32'd0;
        start_frame(32'd55);
`ifdef UNLOAD_CHECKSUM_EN
        get_word(32'd55, 1'b0, -1, 0, "r0_w0");
        get_word(32'd0, 1'b1, 0, 0, "r0_sum");
`else
        get_word(32'd55, 1'b1, -1, 0, "r0_w0");
`endif
        chk(32'(err), 32'd0, "r0_err");
        step();
        chk(32'(busy), 32'd0, "r0_idle");

        // rows == -1: illegal, count word only, sticky err.
        mem[0] = 32'hFFFF_FFFF;
        start_frame(32'd66);
        get_word(32'd66, 1'b1, -1, 0, "neg_w0");
        chk(32'(err), 32'd1, "neg_err");
        chk(32'(out_valid), 32'd0, "neg_finish_valid");
        step();
        chk(32'(busy), 32'd0, "neg_idle");
        chk(32'(err), 32'd1, "neg_err_sticky");

        // rows == MAX_ROWS+1 is also illegal; err cleared by reset first.
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk(32'(err), 32'd0, "big_err_clr");
        mem[0] = 32'd513;
        start_frame(32'd77);
        get_word(32'd77, 1'b1, -1, 0, "big_w0");
        chk(32'(err), 32'd1, "big_err");
        step();

        // Reset while word 2 is on the bus, with done held high through and after reset.
        mem[0] = 32'd3;
        start_frame(32'd120);
        get_word(32'd120, 1'b0, -1, 0, "ab_w0");
        get_word(32'd5, 1'b0, 2, 0, "ab_w1");
        for (int n = 0; n < 20 && !out_valid; n++) step();
        chk(out_data, 32'hFFFF_FFFE, "ab_w2_data");
        out_ready = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        out_ready = 1'b1;
        chk(32'(out_valid), 32'd0, "ab_valid");
        chk(32'(out_last), 32'd0, "ab_last");
        chk(32'(busy), 32'd0, "ab_busy");
        chk(32'(mem_rd_en), 32'd0, "ab_rden");
        for (int n = 0; n < 6; n++) begin
            step();
            chk(32'(busy | out_valid), 32'd0, "ab_hold_idle");
        end
        frame_ref(32'd200, 0, "post");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/result_unloader.md
RESULT_UNLOADER -- requirements
Module: result_unloader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning the data-memory word-address width.
REQ-002 SHALL have parameter RESULT_BASE, default 512, meaning the word address of result[0] in data memory.
REQ-003 SHALL have parameter MAX_ROWS, default 512, meaning the largest legal row count.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port done, input, 1, the CPU completion flag; it may stay high for many cycles.
REQ-007 SHALL have port clock_count, input, 32, the CPU cycle counter.
REQ-008 SHALL have port mem_rd_en, output, 1, the data-memory read strobe.
REQ-009 SHALL have port mem_addr, output, ADDR_W, the data-memory word address.
REQ-010 SHALL have port mem_rd_data, input, 32, the read data, valid exactly 1 cycle after mem_rd_en.
REQ-011 SHALL have port out_valid, output, 1, meaning a stream word is valid.
REQ-012 SHALL have port out_ready, input, 1, the sink acceptance signal.
REQ-013 SHALL have port out_data, output, 32, the stream word.
REQ-014 SHALL have port out_last, output, 1, marking the final word of a frame.
REQ-015 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-016 SHALL have port err, output, 1, a sticky flag for an illegal row count.

Function
REQ-017 SHALL have states IDLE, HDR_RD, HDR_CAP, SEND, FETCH, FILL, SUM, FINISH.
REQ-018 SHALL detect a done rising edge from done high with registered done_q low; the edge is acted on only in IDLE and is otherwise ignored.
REQ-019 SHALL, on an edge in cycle t, latch clock_count and enter HDR_RD at t+1, asserting mem_rd_en with mem_addr=0 for one cycle.
REQ-020 SHALL, in HDR_CAP, register rows=mem_rd_data (address 0 holds the row count; address 1 holds cols, which is unused).
REQ-021 SHALL, in SEND, present frame word 0 as the latched clock_count.
REQ-022 SHALL transfer a word only in a cycle with out_valid and out_ready both high; while out_valid is high and out_ready is low, out_data and out_last SHALL hold stable.
REQ-023 SHALL, after each transfer with words remaining, pass through FETCH (mem_rd_en, mem_addr=RESULT_BASE+i) and FILL (capture) so that out_valid re-asserts 2 cycles after the transfer.
REQ-024 SHALL form a frame of the count word followed by result[0..rows-1] in ascending address order.
REQ-025 SHALL raise out_last on result[rows-1], or on the count word when rows==0.
REQ-026 SHALL treat rows as signed: a value <0 or >MAX_ROWS sets err and sends only the count word with out_last.
REQ-027 SHALL compute result addresses modulo 2^ADDR_W, with no saturation.
REQ-028 SHALL, after the last transfer, spend 1 cycle in FINISH, then go to IDLE, where a new frame requires done to fall and then rise again.
REQ-029 SHALL keep mem_rd_en low in every state except HDR_RD and FETCH.

Reset
REQ-030 SHALL, when reset is high at a clock edge, set state IDLE, out_valid=0, out_last=0, out_data=0, mem_rd_en=0, mem_addr=0, busy=0, err=0, done_q=0, and clear rows, the word index and the checksum.
REQ-031 SHALL abort any frame mid-operation on reset without asserting out_last; a done level held through reset SHALL NOT start a frame.

Configuration
REQ-032 SHALL, with UNLOAD_CHECKSUM_EN defined, append a SUM word after the results equal to the XOR of all result words (0 when rows==0), with out_last moving to the SUM word.
REQ-033 SHALL, without UNLOAD_CHECKSUM_EN, not implement the SUM state or the checksum register.

Structure
REQ-034 SHALL place the state enum and the FRAME_HDR_WORDS=1 constant in the shared package riscv_pkg.
REQ-035 SHALL use no sub-module; a single FSM with datapath registers is sufficient.

Verification
REQ-036 SHALL cover: mem[0]=3 and mem[512..514]=5,-2,7, clock_count=120 when done rises, out_ready=1 -> frame 120,5,-2,7 with out_last on 7 and out_valid re-asserting 2 cycles after each transfer.
REQ-037 SHALL cover: the same frame with out_ready toggling 1010 -> identical frame and data stable during stalls.
REQ-038 SHALL cover: mem[0]=0 -> single word clock_count with out_last and err=0; mem[0]=-1 -> single word and err=1.
REQ-039 SHALL cover: reset pulsed during word 2 -> out_valid=0 the next cycle, no frame while done stays high, new frame only after done falls and rises.
REQ-040 SHALL cover: with UNLOAD_CHECKSUM_EN and results 5,-2,7 -> extra word 5^0xFFFFFFFE^7 = 0xFFFFFFFC carrying out_last.
